mem_bus_arbiter: RTL and testbench

- Shares the single CPU memory bus (we/addr/wd/rd into the memory interface for ROM/RAM/IO) between two requesters: data port (d_) and instruction-fetch port (i_).
- Serialises accesses with a req/gnt/ack handshake and a small FSM.
- Handles the synchronous read latency of the memory behind the bus.
- Sits between the core's fetch/load-store units and the memory interface.

---
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port (data / instruction-fetch) arbiter for the shared memory bus with
// req/gnt/ack handshake and synchronous read latency. Optional macro: ARB_ROUND_ROBIN_EN.
module mem_bus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wd,
  output logic        d_gnt,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wd,
  input  logic [31:0] bus_rd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  localparam logic [2:0] LAT_CNT = 3'(RD_LATENCY);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  logic [31:0] d_rdata_q;
  logic [31:0] i_rdata_q;
  logic        grant_d;
  logic        grant_i;
  logic        in_access;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  // On a tie the port that did not win last time is served; lone requests always win.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == ST_IDLE && !rst) begin
      if (d_req && i_req) begin
        if (last_gnt == OWN_I) grant_d = 1'b1;
        else                   grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          last_gnt <= OWN_I;
    else if (grant_d) last_gnt <= OWN_D;
    else if (grant_i) last_gnt <= OWN_I;
  end
`else
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == ST_IDLE && !rst) begin
      if (d_req)      grant_d = 1'b1;
      else if (i_req) grant_i = 1'b1;
    end
  end
`endif

  // Read completes on the edge where cnt reaches RD_LATENCY; writes take one bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      owner     <= OWN_D;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wd    <= 32'd0;
      d_rdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            owner    <= OWN_D;
            lat_we   <= d_we;
            lat_addr <= d_addr;
            lat_wd   <= d_wd;
            cnt      <= 3'd0;
            state    <= ST_ACCESS;
          end else if (grant_i) begin
            owner    <= OWN_I;
            lat_we   <= 1'b0;
            lat_addr <= i_addr;
            lat_wd   <= 32'd0;
            cnt      <= 3'd0;
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (lat_we) begin
            state <= ST_DONE;
          end else if (cnt == LAT_CNT) begin
            if (owner == OWN_I) i_rdata_q <= bus_rd;
            else                d_rdata_q <= bus_rd;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_access = (state == ST_ACCESS);
  assign bus_we    = in_access && lat_we;
  assign bus_addr  = in_access ? lat_addr : 32'd0;
  assign bus_wd    = in_access ? lat_wd : 32'd0;

  assign d_gnt   = grant_d;
  assign i_gnt   = grant_i;
  assign d_ack   = (state == ST_DONE) && (owner == OWN_D);
  assign i_ack   = (state == ST_DONE) && (owner == OWN_I);
  assign d_rdata = d_rdata_q;
  assign i_rdata = i_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random and directed traffic checked
// against a transaction-level model of arbitration, latency and memory contents.
module tb_mem_bus_arbiter;

  parameter int RD_LATENCY = 1;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE = 32'h1000_0000;
  localparam logic [31:0] IO_BASE  = 32'h2000_0000;

  logic        clk;
  logic        rst;
  logic        d_req, d_we, d_gnt, d_ack;
  logic [31:0] d_addr, d_wd, d_rdata;
  logic        i_req, i_gnt, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wd, bus_rd;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          ack_cycle;
  } exp_t;

  exp_t        exp_q[$];
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          cycle     = 0;

  // Transaction-level model state
  int          free_at = 0;
  int          acc_lo  = 1;
  int          acc_hi  = 0;
  logic        m_we    = 1'b0;
  logic [31:0] m_addr  = 32'd0;
  logic [31:0] m_wd    = 32'd0;
  logic [31:0] last_rd [2];
  logic [31:0] ref_mem [64];
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_was_i = 1'b1;
`endif

  // Memory behind the bus
  logic [31:0] bus_mem [64];
  logic [31:0] rd_pipe [RD_LATENCY];

  mem_bus_arbiter #(.RD_LATENCY(RD_LATENCY)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_ack(i_ack), .i_rdata(i_rdata),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_rd(bus_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [5:0] idx(input logic [31:0] a);
    return {a[29:28], a[5:2]};
  endfunction

  function automatic logic [31:0] default_word(input int i);
    return (32'h9E37_79B1 * 32'(i + 1)) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [1:0] region;
    logic [3:0] word;
    region = 2'($urandom_range(0, 2));
    word   = 4'($urandom_range(0, 15));
    return {2'b00, region, 22'd0, word, 2'b00};
  endfunction

  // Synchronous-read memory: bus_rd reflects the address RD_LATENCY edges earlier
  always @(posedge clk) begin
    if (bus_we) bus_mem[idx(bus_addr)] <= bus_wd;
    rd_pipe[0] <= bus_mem[idx(bus_addr)];
    for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bus_rd = rd_pipe[RD_LATENCY-1];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] wanted);
    check_cnt++;
    if (actual === wanted) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, wanted, cycle);
  endtask

  // Model: expected grants and bus activity, pushing each accepted transaction's response
  initial begin : model_proc
    logic want_d, want_i, in_win, t_we, t_port;
    logic [31:0] t_addr, t_wd, t_data;
    int lat;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cycle >= 1) begin
        in_win = (cycle >= acc_lo) && (cycle <= acc_hi);
        check_output("bus_we", 32'(bus_we), 32'(in_win && m_we));
        check_output("bus_addr", bus_addr, in_win ? m_addr : 32'd0);
        check_output("bus_wd", bus_wd, in_win ? m_wd : 32'd0);

        want_d = 1'b0;
        want_i = 1'b0;
        if (!rst && cycle >= free_at) begin
          if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_was_i) want_d = 1'b1;
            else            want_i = 1'b1;
`else
            want_d = 1'b1;
`endif
          end else begin
            want_d = d_req;
            want_i = i_req;
          end
        end
        check_output("d_gnt", 32'(d_gnt), 32'(want_d));
        check_output("i_gnt", 32'(i_gnt), 32'(want_i));

        if (want_d || want_i) begin
          t_port = want_i;
          t_we   = want_d ? d_we : 1'b0;
          t_addr = want_d ? d_addr : i_addr;
          t_wd   = want_d ? d_wd : 32'd0;
          lat    = t_we ? 2 : RD_LATENCY + 2;
          if (t_we) begin
            ref_mem[idx(t_addr)] = t_wd;
            t_data = last_rd[t_port];
          end else begin
            t_data = ref_mem[idx(t_addr)];
            last_rd[t_port] = t_data;
          end
          e.port = t_port;
          e.data = t_data;
          e.ack_cycle = cycle + lat;
          exp_q.push_back(e);
          free_at = cycle + lat + 1;
          acc_lo  = cycle + 1;
          acc_hi  = cycle + lat - 1;
          m_we    = t_we;
          m_addr  = t_addr;
          m_wd    = t_wd;
`ifdef ARB_ROUND_ROBIN_EN
          last_was_i = t_port;
`endif
        end

        if (rst) begin
          exp_q.delete();
          free_at = cycle + 1;
          acc_lo  = 1;
          acc_hi  = 0;
          last_rd[0] = 32'd0;
          last_rd[1] = 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
          last_was_i = 1'b1;
`endif
        end
      end
    end
  end

  // Monitor: pops the expected response whenever the DUT acknowledges
  initial begin : monitor_proc
    exp_t e;
    forever begin
      @(negedge clk);
      if (cycle >= 1) begin
        if (d_ack || i_ack) begin
          check_output("ack_onehot", 32'(d_ack && i_ack), 32'd0);
          if (exp_q.size() == 0) begin
            check_output("ack_unexpected", {30'd0, i_ack, d_ack}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_output("ack_port", 32'(i_ack), 32'(e.port));
            check_output("ack_cycle", 32'(cycle), 32'(e.ack_cycle));
            check_output("rdata", e.port ? i_rdata : d_rdata, e.data);
          end
        end else if (exp_q.size() != 0 && cycle > exp_q[0].ack_cycle) begin
          e = exp_q.pop_front();
          check_output("ack_missing", {30'd0, i_ack, d_ack}, e.port ? 32'd2 : 32'd1);
        end
      end
    end
  end

  task automatic apply_stimulus(input int pct, input logic d_taken, input logic i_taken);
    if (!d_req || d_taken) begin
      if ($urandom_range(1, 100) <= pct) begin
        d_req  = 1'b1;
        d_we   = 1'($urandom_range(0, 1));
        d_addr = rand_addr();
        d_wd   = $urandom;
      end else begin
        d_req = 1'b0;
      end
    end
    if (!i_req || i_taken) begin
      if ($urandom_range(1, 100) <= pct) begin
        i_req  = 1'b1;
        i_addr = rand_addr();
      end else begin
        i_req = 1'b0;
      end
    end
  endtask

  task automatic run_random(input int n, input int pct);
    logic dg, ig;
    repeat (n) begin
      @(negedge clk);
      dg = d_gnt;
      ig = i_gnt;
      @(posedge clk);
      #1;
      apply_stimulus(pct, dg, ig);
    end
  endtask

  task automatic do_req(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    logic got;
    @(posedge clk);
    #1;
    if (port) begin
      i_req = 1'b1; i_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wd = wd;
    end
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (port ? i_gnt : d_gnt) got = 1'b1;
    end
    if (!got) check_output("gnt_timeout", 32'(port ? i_gnt : d_gnt), 32'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  task automatic do_both(input logic [31:0] da, input logic [31:0] ia);
    logic dg, ig, d_done, i_done;
    @(posedge clk);
    #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = da; d_wd = 32'h1234_5678;
    i_req = 1'b1; i_addr = ia;
    d_done = 1'b0;
    i_done = 1'b0;
    for (int n = 0; n < 60 && !(d_done && i_done); n++) begin
      @(negedge clk);
      dg = d_gnt;
      ig = i_gnt;
      @(posedge clk);
      #1;
      if (dg) begin d_req = 1'b0; d_done = 1'b1; end
      if (ig) begin i_req = 1'b0; i_done = 1'b1; end
    end
    if (!(d_done && i_done)) check_output("both_timeout", {30'd0, i_done, d_done}, 32'd3);
    d_req = 1'b0;
    i_req = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main_proc
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = default_word(i);
      bus_mem[i] = default_word(i);
    end
    for (int k = 0; k < RD_LATENCY; k++) rd_pipe[k] = 32'd0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    rst = 1'b1;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wd = 32'd0;
    i_req = 1'b0; i_addr = 32'd0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("rst_d_ack", 32'(d_ack), 32'd0);
    check_output("rst_i_ack", 32'(i_ack), 32'd0);
    check_output("rst_d_rdata", d_rdata, 32'd0);
    check_output("rst_i_rdata", i_rdata, 32'd0);

    do_req(1'b1, 1'b0, ROM_BASE + 32'h10, 32'd0);
    do_req(1'b0, 1'b1, RAM_BASE + 32'h8, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b0, RAM_BASE + 32'h8, 32'd0);
    do_both(ROM_BASE + 32'h3C, ROM_BASE + 32'h14);

    // Both ports hammering: exercises back-to-back tie arbitration
    run_random(24, 100);
    run_random(60, 0);

    run_random(300, 60);
    run_random(60, 0);

    do_req(1'b0, 1'b0, IO_BASE, 32'd0);
    do_req(1'b0, 1'b1, IO_BASE + 32'h4, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, IO_BASE + 32'h4, 32'd0);
    repeat (RD_LATENCY + 4) @(posedge clk);

    // Reset in the first ACCESS cycle of a read: the read must vanish without an ack
    do_req(1'b0, 1'b0, RAM_BASE + 32'h8, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("midrst_d_rdata", d_rdata, 32'd0);
    check_output("midrst_i_rdata", i_rdata, 32'd0);
    do_req(1'b1, 1'b0, ROM_BASE + 32'h10, 32'd0);

    repeat (RD_LATENCY + 10) @(posedge clk);
    @(negedge clk);
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
